// File: rtl/inv_quarter_sha_iter_pkg.sv
// Shared constants for the iterative inverse quarter-round engine:
// FSM encoding, word width and per-step rotation amounts.
package inv_quarter_sha_iter_pkg;

    localparam int unsigned WordW = 32;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Rotation amount used by inverse step 0..3.
    localparam int unsigned RotAmt [4] = '{18, 13, 9, 7};

    function automatic logic [WordW-1:0] rotl(input logic [WordW-1:0] x,
                                              input int unsigned     n);
        rotl = (x << n) | (x >> (WordW - n));
    endfunction

endpackage

// File: rtl/inv_qsha_step.sv
// One combinational inverse step: updates exactly one of the four words,
// selected by the step index, and passes the other three through.
module inv_qsha_step
    import inv_quarter_sha_iter_pkg::*;
(
    input  logic [WordW-1:0] a,
    input  logic [WordW-1:0] b,
    input  logic [WordW-1:0] c,
    input  logic [WordW-1:0] d,
    input  logic [1:0]       step,
    output logic [WordW-1:0] a_nx,
    output logic [WordW-1:0] b_nx,
    output logic [WordW-1:0] c_nx,
    output logic [WordW-1:0] d_nx
);

    logic [WordW-1:0] sum;

    always_comb begin
        a_nx = a;
        b_nx = b;
        c_nx = c;
        d_nx = d;
        sum  = '0;
        case (step)
            2'd0: begin
                sum  = c + d;
                a_nx = a ^ rotl(sum, RotAmt[0]);
            end
            2'd1: begin
                sum  = c + b;
                d_nx = d ^ rotl(sum, RotAmt[1]);
            end
            2'd2: begin
                sum  = a + b;
                c_nx = c ^ rotl(sum, RotAmt[2]);
            end
            default: begin
                sum  = a + d;
                b_nx = b ^ rotl(sum, RotAmt[3]);
            end
        endcase
    end

endmodule

// File: rtl/inv_quarter_sha_iter.sv
// Iterative inverse of a Salsa-style quarter round: undoes `rounds` forward
// quarter rounds one word-update per clock, with valid/ready on both sides.
module inv_quarter_sha_iter
    import inv_quarter_sha_iter_pkg::*;
#(
    parameter int unsigned RW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WordW-1:0] a_in,
    input  logic [WordW-1:0] b_in,
    input  logic [WordW-1:0] c_in,
    input  logic [WordW-1:0] d_in,
    input  logic [RW-1:0]    rounds,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WordW-1:0] a_out,
    output logic [WordW-1:0] b_out,
    output logic [WordW-1:0] c_out,
    output logic [WordW-1:0] d_out,
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [RW-1:0]    round_q, round_d;
    logic [WordW-1:0] a_q, b_q, c_q, d_q;
    logic [WordW-1:0] a_d, b_d, c_d, d_d;
    logic [WordW-1:0] a_nx, b_nx, c_nx, d_nx;

    inv_qsha_step u_step (
        .a    (a_q),
        .b    (b_q),
        .c    (c_q),
        .d    (d_q),
        .step (step_q),
        .a_nx (a_nx),
        .b_nx (b_nx),
        .c_nx (c_nx),
        .d_nx (d_nx)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        round_d = round_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    c_d     = c_in;
                    d_d     = d_in;
                    round_d = rounds;
                    step_d  = 2'd0;
                    state_d = (rounds == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                a_d    = a_nx;
                b_d    = b_nx;
                c_d    = c_nx;
                d_d    = d_nx;
                step_d = step_q + 2'd1;
                // The counter is only ever decremented from a non-zero value,
                // so the all-ones round count cannot wrap.
                if (step_q == 2'd3) begin
                    round_d = round_q - RW'(1);
                    if (round_q == RW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            round_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            round_q <= round_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign out_valid = (state_q == StDone);
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign c_out     = c_q;
    assign d_out     = d_q;

endmodule

// File: tb/tb_inv_quarter_sha_iter.sv
// Self-checking bench: words are scrambled with a forward quarter-round model,
// fed to the DUT, and the recovered words compared against the originals.
module tb_inv_quarter_sha_iter;

    localparam int unsigned RW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   a_in, b_in, c_in, d_in;
    logic [RW-1:0] rounds;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   a_out, b_out, c_out, d_out;
    logic          busy;

    int errors = 0;
    int checks = 0;

    inv_quarter_sha_iter #(.RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .rounds    (rounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out),
        .d_out     (d_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Golden forward quarter round on {a,b,c,d}.
    function automatic logic [127:0] fwd(input logic [127:0] s);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = s;
        b = b ^ rl(32'(a + d), 7);
        c = c ^ rl(32'(b + a), 9);
        d = d ^ rl(32'(c + b), 13);
        a = a ^ rl(32'(d + c), 18);
        return {a, b, c, d};
    endfunction

    // Whole-round inverse: undo the forward updates in reverse order.
    function automatic logic [127:0] inv(input logic [127:0] s);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = s;
        a = a ^ rl(32'(d + c), 18);
        d = d ^ rl(32'(c + b), 13);
        c = c ^ rl(32'(b + a), 9);
        b = b ^ rl(32'(a + d), 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accepts one word set, then counts edges after the accept edge until
    // out_valid. Optionally wiggles in_valid/rounds/data while not idle.
    task automatic send(input logic [127:0] s, input int r, input bit pulse,
                        output int lat, output bit timeout);
        {a_in, b_in, c_in, d_in} = s;
        rounds   = RW'(r);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        timeout  = 1'b0;
        while (!out_valid && !timeout) begin
            if (pulse) begin
                in_valid = 1'($urandom_range(0, 1));
                rounds   = RW'($urandom);
                {a_in, b_in, c_in, d_in} = rnd128();
            end
            @(posedge clk);
            #1;
            lat++;
            if (lat > 4 * 256 + 8) timeout = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got in_ready/out_valid/busy=%b want 100",
                     {in_ready, out_valid, busy});
        end
        checks++;
        if ({a_out, b_out, c_out, d_out} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {a_out, b_out, c_out, d_out});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [127:0] vin [2];
        logic [127:0] vexp [2];
        int lat;
        bit to;
        vin[0]  = {32'h08008145, 32'h00000080, 32'h00010200, 32'h20500000};
        vexp[0] = {32'h00000001, 32'h0, 32'h0, 32'h0};
        vin[1]  = {32'h88000100, 32'h00000001, 32'h00000200, 32'h00402000};
        vexp[1] = {32'h0, 32'h00000001, 32'h0, 32'h0};
        for (int i = 0; i < 2; i++) begin
            send(vin[i], 1, 1'b0, lat, to);
            checks++;
            if (to || lat != 4) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d (timeout=%0d) want 4", i, lat, to);
            end
            checks++;
            if ({a_out, b_out, c_out, d_out} !== vexp[i]) begin
                errors++;
                $display("FAIL vec%0d_data: got %h want %h", i,
                         {a_out, b_out, c_out, d_out}, vexp[i]);
            end
            handshake();
        end
    endtask

    task automatic test_passthrough();
        logic [127:0] s;
        int lat;
        bit to;
        s = {32'hDEADBEEF, 32'h1, 32'h2, 32'h3};
        send(s, 0, 1'b0, lat, to);
        // With rounds==0 out_valid is already up in the cycle after accept.
        checks++;
        if (to || lat != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pass_latency: got %0d busy=%b want 0 busy=0", lat, busy);
        end
        checks++;
        if ({a_out, b_out, c_out, d_out} !== s) begin
            errors++;
            $display("FAIL pass_data: got %h want %h", {a_out, b_out, c_out, d_out}, s);
        end
        handshake();
    endtask

    task automatic test_random();
        logic [127:0] x, s, held;
        int r, lat;
        bit to;
        for (int it = 0; it < 5; it++) begin
            r = (it == 0) ? 255 : int'($urandom_range(1, 255));
            x = rnd128();
            s = x;
            for (int k = 0; k < r; k++) s = fwd(s);
            send(s, r, 1'b1, lat, to);
            checks++;
            if (to || lat != 4 * r) begin
                errors++;
                $display("FAIL rand%0d_latency: got %0d (timeout=%0d) want %0d",
                         it, lat, to, 4 * r);
            end
            checks++;
            if ({a_out, b_out, c_out, d_out} !== x) begin
                errors++;
                $display("FAIL rand%0d_data R=%0d: got %h want %h", it, r,
                         {a_out, b_out, c_out, d_out}, x);
            end
            held = {a_out, b_out, c_out, d_out};
            for (int h = 0; h < 10; h++) begin
                in_valid = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                checks++;
                if (!out_valid || {a_out, b_out, c_out, d_out} !== held) begin
                    errors++;
                    $display("FAIL rand%0d_hold cyc%0d: got valid=%b %h want valid=1 %h",
                             it, h, out_valid, {a_out, b_out, c_out, d_out}, held);
                end
            end
            in_valid = 1'b0;
            handshake();
            checks++;
            if ({in_ready, out_valid, busy} !== 3'b100) begin
                errors++;
                $display("FAIL rand%0d_release: got in_ready/out_valid/busy=%b want 100",
                         it, {in_ready, out_valid, busy});
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] x;
        int seen, lat;
        bit to;
        x = rnd128();
        {a_in, b_in, c_in, d_in} = fwd(fwd(x));
        rounds   = RW'(2);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 ||
            {a_out, b_out, c_out, d_out} !== 128'h0) begin
            errors++;
            $display("FAIL midrun_reset: got flags=%b data=%h want flags=100 data=0",
                     {in_ready, out_valid, busy}, {a_out, b_out, c_out, d_out});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrun_no_valid: got %0d out_valid cycles want 0", seen);
        end
        x = rnd128();
        send(fwd(x), 1, 1'b0, lat, to);
        checks++;
        if (to || {a_out, b_out, c_out, d_out} !== x) begin
            errors++;
            $display("FAIL midrun_next: got %h (timeout=%0d) want %h",
                     {a_out, b_out, c_out, d_out}, to, x);
        end
        handshake();
    endtask

    task automatic test_all_ones();
        logic [127:0] s, e;
        int lat;
        bit to;
        s = {128{1'b1}};
        e = inv(inv(inv(s)));
        send(s, 3, 1'b0, lat, to);
        checks++;
        if (to || lat != 12) begin
            errors++;
            $display("FAIL ones_latency: got %0d (timeout=%0d) want 12", lat, to);
        end
        checks++;
        if ({a_out, b_out, c_out, d_out} !== e) begin
            errors++;
            $display("FAIL ones_data: got %h want %h", {a_out, b_out, c_out, d_out}, e);
        end
        handshake();
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rounds    = '0;
        {a_in, b_in, c_in, d_in} = '0;
        test_reset();
        test_vectors();
        test_passthrough();
        test_random();
        test_reset_mid_run();
        test_all_ones();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_quarter_sha_iter.md
INV_QUARTER_SHA_ITER -- requirements
Module: inv_quarter_sha_iter

Interface
REQ-001 SHALL have parameter RW, default 8: width of the round-count input.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  input word set valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an input word set.
REQ-006 SHALL have ports a_in, b_in, c_in, d_in  input  32 each  state words after forward quarter rounds.
REQ-007 SHALL have port rounds  input  RW  number of forward quarter rounds to undo; sampled at accept.
REQ-008 SHALL have port out_valid  output  1  recovered words valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have ports a_out, b_out, c_out, d_out  output  32 each  recovered pre-round words.
REQ-011 SHALL have port busy  output  1  high while inverse steps are in progress.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE; in_ready = (state==IDLE); busy = (state==RUN); out_valid = (state==DONE).
REQ-013 Accept SHALL occur on in_valid && in_ready; this loads a/b/c/d working registers from a_in..d_in, latches rounds into a round counter, and clears a 2-bit step counter.
REQ-014 On accept with rounds==0 SHALL go IDLE->DONE; data passes through unchanged.
REQ-015 On accept with rounds!=0 SHALL go IDLE->RUN and execute exactly one inverse step per clock.
REQ-016 Step 0 SHALL compute a = a ^ rotl(c+d, 18).
REQ-017 Step 1 SHALL compute d = d ^ rotl(c+b, 13).
REQ-018 Step 2 SHALL compute c = c ^ rotl(a+b, 9).
REQ-019 Step 3 SHALL compute b = b ^ rotl(a+d, 7).
REQ-020 Each step SHALL use the current register values, updated by the preceding steps.
REQ-021 All additions SHALL be modulo 2^32, with the carry discarded; rotl SHALL be a 32-bit left rotate.
REQ-022 After step 3 SHALL decrement the round counter; the step counter wraps 3->0.
REQ-023 When step 3 completes with round counter==1, SHALL go RUN->DONE.
REQ-024 Latency SHALL be 4*rounds cycles from the accept edge to out_valid high; for rounds==0 it SHALL be 1 cycle.
REQ-025 a_out..d_out SHALL be driven directly from the working registers; they are meaningful only while out_valid is high.
REQ-026 In DONE, outputs SHALL hold stable while out_ready is low (backpressure of any length).
REQ-027 On out_valid && out_ready SHALL go DONE->IDLE; in_ready rises the next cycle, so there is no same-cycle accept and minimum throughput is 4*rounds+2 cycles per result.
REQ-028 in_valid and changes to rounds SHALL be ignored outside IDLE.
REQ-029 rounds = 2^RW-1 SHALL complete correctly with no counter overflow.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, the working registers to 0, and both counters to 0.
REQ-031 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, a_out..d_out=0.
REQ-032 Reset asserted during RUN or DONE SHALL abort the operation; the partial result is discarded, and no out_valid occurs after release.
REQ-033 Release of rst_n SHALL take effect synchronously to clk; the first accept is possible on the first rising edge after release.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the rotation constants 18/13/9/7 indexed by step, and the 32-bit word width constant.
REQ-035 SHALL instantiate one combinational sub-module inv_qsha_step: inputs a, b, c, d and a 2-bit step index; outputs the four next-state words.
REQ-036 The forward quarter-round module already in the codebase SHALL serve as the bench golden model and SHALL NOT be instantiated in RTL.

Verification
REQ-037 rounds=1, in (0x08008145, 0x00000080, 0x00010200, 0x20500000) -> out (0x00000001, 0, 0, 0), out_valid exactly 4 cycles after accept.
REQ-038 rounds=1, in (0x88000100, 0x00000001, 0x00000200, 0x00402000) -> out (0, 0x00000001, 0, 0).
REQ-039 rounds=0, in (0xDEADBEEF, 1, 2, 3) -> identical words out 1 cycle after accept; busy never high.
REQ-040 Random X run through the golden model R=1..255 times, then fed in with rounds=R -> out == X; out_ready held low 10 cycles -> outputs stable throughout, and in_valid pulses during RUN/DONE ignored.
REQ-041 rst_n pulsed low mid-RUN at step 2 -> outputs immediately 0 and in_ready=1; no out_valid after release; next transaction correct.
REQ-042 All-ones input with rounds=3 -> matches golden-model inverse, confirming mod-2^32 carry drop.
